// File: rtl/ripple_down_counter.sv
// Loadable WIDTH-bit down counter with a one-cycle terminal-count pulse and a busy flag.
// Optional feature: define AUTO_RELOAD_EN for periodic reload from the last loaded value on expiry.
module ripple_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nextQ;
  logic [WIDTH-1:0] r_rld;
  logic [WIDTH-1:0] w_nextRld;
  logic             r_tc;
  logic             w_nextTc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_q     <= ZERO;
      r_rld   <= ZERO;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_q     <= w_nextQ;
      r_rld   <= w_nextRld;
      r_tc    <= w_nextTc;
    end
  end

  // Load beats decrement; a RUN state with q==0 cannot normally occur but falls back to IDLE without tc.
  always_comb begin
    w_nextState = r_state;
    w_nextQ     = r_q;
    w_nextRld   = r_rld;
    w_nextTc    = 1'b0;
    if (load) begin
      w_nextQ     = load_val;
      w_nextRld   = load_val;
      w_nextState = (load_val != ZERO) ? RUN : IDLE;
    end else if (r_state == RUN && en) begin
      if (r_q > ONE) begin
        w_nextQ = r_q - ONE;
      end else if (r_q == ONE) begin
        w_nextTc = 1'b1;
`ifdef AUTO_RELOAD_EN
        w_nextQ     = r_rld;
        w_nextState = RUN;
`else
        w_nextQ     = ZERO;
        w_nextState = IDLE;
`endif
      end else begin
        w_nextState = IDLE;
      end
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign busy = (r_state == RUN);

endmodule
